// File: rtl/pong_pkg.sv
// Shared Pong constants: playfield geometry, paddle reset position, tracker FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 64;
    localparam int Y_W      = 10;

    // Paddle centred vertically on reset.
    localparam logic [Y_W-1:0] PADDLE_Y_INIT = Y_W'((SCREEN_H - PADDLE_H) / 2);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,  // collecting samples for the current window
        S_FILT  = 2'd1,  // deadband decision on the fresh average
        S_SCALE = 2'd2   // map filtered value onto the playfield
    } track_state_e;

endpackage

// File: rtl/pot_avg_filter.sv
// Block-averages 2^AVG_LOG2 ADC samples and applies a deadband before accepting a new value.
// Latency: window average registered on the last sample edge; filt updated one edge later.
// Backpressure: none; every sample_tick is consumed, and windows restart back to back.
//
// Ports:
//   sys_clk, reset   clock, async active-low reset
//   adc_value        8-bit potentiometer reading, sampled when sample_tick=1
//   sample_tick      one-cycle sample strobe
//   win_done         combinational: this sample_tick completes a window
//   filt             deadband-filtered average
//   filt_update      one-cycle pulse the cycle after filt was overwritten
module pot_avg_filter
    import pong_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DEADBAND = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] adc_value,
    input  logic       sample_tick,
    output logic       win_done,
    output logic [7:0] filt,
    output logic       filt_update
);

    localparam int                  SUM_W    = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
    localparam logic [7:0]          DB       = 8'(DEADBAND);

    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [7:0]          avg_q, avg_d;
    logic                avg_vld_q, avg_vld_d;
    logic [7:0]          filt_q, filt_d;
    logic                have_q, have_d;
    logic                upd_q, upd_d;

    logic [SUM_W-1:0] sum_full;
    logic [7:0]       diff;

    assign sum_full = sum_q + SUM_W'(adc_value);
    assign win_done = sample_tick && (cnt_q == CNT_LAST);
    assign diff     = (avg_q >= filt_q) ? (avg_q - filt_q) : (filt_q - avg_q);

    always_comb begin
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        filt_d    = filt_q;
        have_d    = have_q;
        upd_d     = 1'b0;

        if (sample_tick) begin
            if (win_done) begin
                // Include the completing sample directly so no cycle is lost.
                avg_d     = sum_full[SUM_W-1:AVG_LOG2];
                avg_vld_d = 1'b1;
                sum_d     = '0;
                cnt_d     = '0;
            end else begin
                sum_d = sum_full;
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end

        // A window takes at least 2^AVG_LOG2 cycles, so avg_vld_q never
        // overlaps with the next win_done.
        if (avg_vld_q) begin
            if (!have_q || (diff > DB)) begin
                filt_d = avg_q;
                upd_d  = 1'b1;
            end
            have_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sum_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            filt_q    <= '0;
            have_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
            filt_q    <= filt_d;
            have_q    <= have_d;
            upd_q     <= upd_d;
        end
    end

    assign filt        = filt_q;
    assign filt_update = upd_q;

endmodule

// File: rtl/paddle_tracker.sv
// Turns filtered potentiometer readings into a slew-limited paddle Y position.
// Latency: target ready 2 edges after the window-completing sample; paddle moves on frame_tick.
// Backpressure: none; strobes are consumed in the cycle they are asserted.
//
// Ports:
//   sys_clk, reset   clock, async active-low reset
//   adc_value        registered 8-bit potentiometer value
//   sample_tick      one-cycle sample strobe
//   frame_tick       one-cycle frame-start strobe; paddle step happens here
//   paddle_y         top row of paddle, 0..SCREEN_H-PADDLE_H
//   paddle_valid     sticky, set once the first target has been computed
//   moving           paddle_y changed on the most recent frame_tick
module paddle_tracker
    import pong_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DEADBAND = 2,
    parameter int MAX_STEP = 8
) (
    input  logic           sys_clk,
    input  logic           reset,
    input  logic [7:0]     adc_value,
    input  logic           sample_tick,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_y,
    output logic           paddle_valid,
    output logic           moving
);

    localparam int                    SPAN_W = 9;
    localparam logic [SPAN_W-1:0]     SPAN   = SPAN_W'(SCREEN_H - PADDLE_H);
    localparam logic signed [Y_W:0]   STEP_S = (Y_W+1)'(MAX_STEP);
    localparam logic [Y_W-1:0]        STEP_U = Y_W'(MAX_STEP);

    logic       win_done;
    logic [7:0] filt;
    logic       filt_update;

    pot_avg_filter #(
        .AVG_LOG2 (AVG_LOG2),
        .DEADBAND (DEADBAND)
    ) u_filter (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .adc_value   (adc_value),
        .sample_tick (sample_tick),
        .win_done    (win_done),
        .filt        (filt),
        .filt_update (filt_update)
    );

    track_state_e      state_q, state_d;
    logic [Y_W-1:0]    target_q, target_d;
    logic [Y_W-1:0]    paddle_y_q, paddle_y_d;
    logic              valid_q, valid_d;
    logic              moving_q, moving_d;

    logic [8+SPAN_W-1:0] prod;
    logic signed [Y_W:0] diff;

    // filt*SPAN/256 never exceeds SPAN, so the target is always in range.
    assign prod = filt * SPAN;
    // One extra bit keeps the difference signed without wrap at either end.
    assign diff = $signed({1'b0, target_q}) - $signed({1'b0, paddle_y_q});

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        paddle_y_d = paddle_y_q;
        valid_d    = valid_q;
        moving_d   = moving_q;

        case (state_q)
            S_FILL:  if (win_done) state_d = S_FILT;
            S_FILT:  state_d = S_SCALE;
            S_SCALE: begin
                // An unchanged filt would rescale to the same target.
                if (filt_update) begin
                    target_d = {1'b0, prod[8+SPAN_W-1:8]};
                end
                valid_d = 1'b1;
                state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase

        // Uses the target registered before this edge, even if S_SCALE
        // is writing a new one in the same cycle.
        if (frame_tick) begin
            if (!valid_q) begin
                moving_d = 1'b0;
            end else begin
                moving_d = (diff != '0);
                if ((diff <= STEP_S) && (diff >= -STEP_S)) begin
                    paddle_y_d = target_q;
                end else if (diff > 0) begin
                    paddle_y_d = paddle_y_q + STEP_U;
                end else begin
                    paddle_y_d = paddle_y_q - STEP_U;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FILL;
            target_q   <= '0;
            paddle_y_q <= PADDLE_Y_INIT;
            valid_q    <= 1'b0;
            moving_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            paddle_y_q <= paddle_y_d;
            valid_q    <= valid_d;
            moving_q   <= moving_d;
        end
    end

    assign paddle_y     = paddle_y_q;
    assign paddle_valid = valid_q;
    assign moving       = moving_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed self-checking bench for paddle_tracker.
// Latency: n/a.
// Backpressure: n/a.
module tb_paddle_tracker;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic [7:0] adc_value;
    logic       sample_tick;
    logic       frame_tick;
    logic [9:0] paddle_y;
    logic       paddle_valid;
    logic       moving;

    int n_chk  = 0;
    int n_fail = 0;

    paddle_tracker dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .adc_value    (adc_value),
        .sample_tick  (sample_tick),
        .frame_tick   (frame_tick),
        .paddle_y     (paddle_y),
        .paddle_valid (paddle_valid),
        .moving       (moving)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of strobes; returns #1 after the capturing edge.
    task automatic step(input logic s, input logic f, input logic [7:0] v);
        @(negedge sys_clk);
        sample_tick = s;
        frame_tick  = f;
        adc_value   = v;
        @(posedge sys_clk);
        #1;
        sample_tick = 1'b0;
        frame_tick  = 1'b0;
    endtask

    task automatic feed4(input logic [7:0] v);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, v);
    endtask

    initial begin
        reset       = 1'b0;
        adc_value   = 8'd0;
        sample_tick = 1'b0;
        frame_tick  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_y", 16'(paddle_y), 16'd208);
        chk("rst_valid", 16'(paddle_valid), 16'd0);
        chk("rst_moving", 16'(moving), 16'd0);
        @(negedge sys_clk);
        reset = 1'b1;

        // 1: frame ticks before any average do nothing
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("t1_y", 16'(paddle_y), 16'd208);
            chk("t1_moving", 16'(moving), 16'd0);
            chk("t1_valid", 16'(paddle_valid), 16'd0);
        end

        // 2: full-scale input, valid two cycles after the 4th sample, slew to 414
        feed4(8'd255);
        chk("t2_valid_n", 16'(paddle_valid), 16'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("t2_valid_n1", 16'(paddle_valid), 16'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("t2_valid_n2", 16'(paddle_valid), 16'd1);
        for (int k = 1; k <= 26; k++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("t2_y", 16'(paddle_y), (k < 26) ? 16'(208 + 8 * k) : 16'd414);
            chk("t2_moving", 16'(moving), 16'd1);
        end
        step(1'b0, 1'b1, 8'd0);
        chk("t2_y_end", 16'(paddle_y), 16'd414);
        chk("t2_moving_end", 16'(moving), 16'd0);

        // 3: settle at filt=128 (target 208), then deadband
        feed4(8'd128);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 26; k++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("t3_y", 16'(paddle_y), (k < 26) ? 16'(414 - 8 * k) : 16'd208);
        end
        step(1'b0, 1'b1, 8'd0);
        chk("t3_settle_moving", 16'(moving), 16'd0);
        step(1'b1, 1'b0, 8'd129);
        step(1'b1, 1'b0, 8'd129);
        step(1'b1, 1'b0, 8'd130);
        step(1'b1, 1'b0, 8'd130);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        chk("t3_db_y", 16'(paddle_y), 16'd208);
        chk("t3_db_moving", 16'(moving), 16'd0);
        feed4(8'd131);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        chk("t3_131_y", 16'(paddle_y), 16'd212);
        chk("t3_131_moving", 16'(moving), 16'd1);
        step(1'b0, 1'b1, 8'd0);
        chk("t3_131_still", 16'(moving), 16'd0);

        // 4: slew down to 0 without underflow
        feed4(8'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 26; k++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("t4_y", 16'(paddle_y), 16'(212 - 8 * k));
        end
        step(1'b0, 1'b1, 8'd0);
        chk("t4_y_zero", 16'(paddle_y), 16'd0);
        chk("t4_moving_last", 16'(moving), 16'd1);
        step(1'b0, 1'b1, 8'd0);
        chk("t4_y_hold", 16'(paddle_y), 16'd0);
        chk("t4_moving_stop", 16'(moving), 16'd0);

        // 5: reset mid-window discards partial sums
        step(1'b1, 1'b0, 8'd200);
        step(1'b1, 1'b0, 8'd200);
        @(negedge sys_clk);
        reset = 1'b0;
        #1;
        chk("t5_rst_y", 16'(paddle_y), 16'd208);
        chk("t5_rst_valid", 16'(paddle_valid), 16'd0);
        chk("t5_rst_moving", 16'(moving), 16'd0);
        @(negedge sys_clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'd64);
        step(1'b1, 1'b0, 8'd64);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("t5_half_valid", 16'(paddle_valid), 16'd0);
        step(1'b1, 1'b0, 8'd64);
        step(1'b1, 1'b0, 8'd64);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("t5_valid", 16'(paddle_valid), 16'd1);
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("t5_y", 16'(paddle_y), 16'(208 - 8 * k));
        end
        step(1'b0, 1'b1, 8'd0);
        chk("t5_y_end", 16'(paddle_y), 16'd104);
        chk("t5_moving_end", 16'(moving), 16'd0);

        // 6: frame_tick on the window-completing edge uses the old target
        step(1'b1, 1'b0, 8'd255);
        step(1'b1, 1'b0, 8'd255);
        step(1'b1, 1'b0, 8'd255);
        step(1'b1, 1'b1, 8'd255);
        chk("t6_same_y", 16'(paddle_y), 16'd104);
        chk("t6_same_moving", 16'(moving), 16'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        chk("t6_next_y", 16'(paddle_y), 16'd112);
        chk("t6_next_moving", 16'(moving), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
